// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - datapath handshake/strobe bundle for the multicycle control FSM
//
// Purpose: groups every controller <-> datapath/memory signal so the
// controller and the datapath connect through one port.
//
// Signals (direction seen from the controller, modport master):
//   opcode     in   5  instr[6:2] from IR, valid from DECODE onward
//   br_taken   in   1  branch comparator result, sampled in EXEC
//   imem_ready in   1  instruction memory completion
//   dmem_ready in   1  data memory completion
//   imem_req   out  1  instruction fetch request
//   ir_we      out  1  IR load strobe
//   pc_we      out  1  PC update strobe
//   pc_sel     out  2  0=PC+4, 1=PC+imm, 2=ALU result with bit0 cleared
//   rf_we      out  1  register file write enable
//   wb_sel     out  2  0=ALU, 1=load data, 2=PC+4
//   dmem_req   out  1  data memory request
//   dmem_we    out  1  data memory write (store)
//   state      out  3  current FSM state (debug)
//   halted     out  1  sticky halt
//   illegal    out  1  sticky illegal-opcode flag
//   bus_err    out  1  sticky memory-timeout flag
//   instret    out 32  retired instruction count
interface multicycle_ctrl_if;
  logic [4:0]  opcode;
  logic        br_taken;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic [2:0]  state;
  logic        halted;
  logic        illegal;
  logic        bus_err;
  logic [31:0] instret;

  modport master (
    input  opcode, br_taken, imem_ready, dmem_ready,
    output imem_req, ir_we, pc_we, pc_sel, rf_we, wb_sel, dmem_req, dmem_we,
    output state, halted, illegal, bus_err, instret
  );

  modport slave (
    output opcode, br_taken, imem_ready, dmem_ready,
    input  imem_req, ir_we, pc_we, pc_sel, rf_we, wb_sel, dmem_req, dmem_we,
    input  state, halted, illegal, bus_err, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM (fetch/decode/exec/mem/wb)
//
// Purpose: sequences the RV32I datapath over several cycles, drives the PC,
// IR, register-file and data-memory strobes plus PC/writeback mux selects,
// detects illegal opcodes and memory timeouts (sticky halt) and counts
// retired instructions.
//
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   bus  multicycle_ctrl_if.master (see rtl/multicycle_ctrl_if.sv)
//
// Parameters:
//   MEM_TIMEOUT  cycles a memory request may wait for ready before bus error
//   CNT_W        width of the wait counter (MEM_TIMEOUT must fit in it)
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q;
  logic [4:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      instret_q;
  logic             illegal_q;
  logic             bus_err_q;

  logic       imem_req_d;
  logic       ir_we_d;
  logic       pc_we_d;
  logic [1:0] pc_sel_d;
  logic       rf_we_d;
  logic [1:0] wb_sel_d;
  logic       dmem_req_d;
  logic       dmem_we_d;

  function automatic logic is_legal(input logic [4:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  // Strobes are decoded combinationally from the current state, the latched
  // opcode and the ready inputs; reset masks them all so an in-flight
  // request is dropped in the same cycle rst is seen.
  always_comb begin
    imem_req_d = 1'b0;
    ir_we_d    = 1'b0;
    pc_we_d    = 1'b0;
    pc_sel_d   = 2'd0;
    rf_we_d    = 1'b0;
    wb_sel_d   = 2'd0;
    dmem_req_d = 1'b0;
    dmem_we_d  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          imem_req_d = 1'b1;
          ir_we_d    = bus.imem_ready;
        end
        S_EXEC: begin
          if (op_q == OP_BRANCH) begin
            pc_we_d  = 1'b1;
            pc_sel_d = bus.br_taken ? 2'd1 : 2'd0;
          end
        end
        S_MEM: begin
          dmem_req_d = 1'b1;
          dmem_we_d  = (op_q == OP_STORE);
          // A store retires directly from MEM; loads still need WB.
          if (bus.dmem_ready && op_q == OP_STORE) begin
            pc_we_d = 1'b1;
          end
        end
        S_WB: begin
          rf_we_d = 1'b1;
          pc_we_d = 1'b1;
          case (op_q)
            OP_LOAD: wb_sel_d = 2'd1;
            OP_JAL:  begin wb_sel_d = 2'd2; pc_sel_d = 2'd1; end
            OP_JALR: begin wb_sel_d = 2'd2; pc_sel_d = 2'd2; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Single registered FSM: state, latched opcode, wait counter, sticky flags
  // and the retire counter. The final pc_we of an instruction is its retire
  // point, so instret simply follows pc_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= 5'd0;
      cnt_q     <= '0;
      instret_q <= 32'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (pc_we_d) begin
        instret_q <= instret_q + 32'd1;
      end
      case (state_q)
        S_FETCH: begin
          // Ready in the same cycle as the timeout still completes the fetch.
          if (bus.imem_ready) begin
            state_q <= S_DECODE;
          end else if (cnt_q == TIMEOUT_C) begin
            state_q   <= S_HALT;
            bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DECODE: begin
          op_q <= bus.opcode;
          if (is_legal(bus.opcode)) begin
            state_q <= S_EXEC;
          end else begin
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (op_q == OP_BRANCH) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
          end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
            state_q <= S_MEM;
            cnt_q   <= '0;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            if (op_q == OP_STORE) begin
              state_q <= S_FETCH;
              cnt_q   <= '0;
            end else begin
              state_q <= S_WB;
            end
          end else if (cnt_q == TIMEOUT_C) begin
            state_q   <= S_HALT;
            bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          cnt_q   <= '0;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        // Unused encodings are treated as a fatal condition.
        default: begin
          state_q <= S_HALT;
        end
      endcase
    end
  end

  assign bus.imem_req = imem_req_d;
  assign bus.ir_we    = ir_we_d;
  assign bus.pc_we    = pc_we_d;
  assign bus.pc_sel   = pc_sel_d;
  assign bus.rf_we    = rf_we_d;
  assign bus.wb_sel   = wb_sel_d;
  assign bus.dmem_req = dmem_req_d;
  assign bus.dmem_we  = dmem_we_d;
  assign bus.state    = state_q;
  assign bus.halted   = (state_q == S_HALT);
  assign bus.illegal  = illegal_q;
  assign bus.bus_err  = bus_err_q;
  assign bus.instret  = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {imem_req, ir_we, pc_we, pc_sel[1:0], rf_we, wb_sel[1:0], dmem_req, dmem_we}
  logic [9:0] strobes;
  assign strobes = {bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_sel,
                    bus.rf_we, bus.wb_sel, bus.dmem_req, bus.dmem_we};

  localparam logic [9:0] NONE = 10'd0;

  function automatic logic [9:0] sb(input logic ireq, input logic irwe, input logic pcwe,
                                    input logic [1:0] psel, input logic rfwe,
                                    input logic [1:0] wsel, input logic dreq, input logic dwe);
    return {ireq, irwe, pcwe, psel, rfwe, wsel, dreq, dwe};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge with inputs already set: checks
  // state and strobes mid-cycle, then advances one clock.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [9:0] exp_sb);
    #2;
    chk({tag, " state"}, 32'(bus.state), 32'(st));
    chk({tag, " strobes"}, 32'(strobes), 32'(exp_sb));
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst strobes", 32'(strobes), 32'(NONE));
    tick();
    rst = 1'b0;
    chk("rst state", 32'(bus.state), 32'd0);
    chk("rst flags", {29'd0, bus.halted, bus.illegal, bus.bus_err}, 32'd0);
    chk("rst instret", bus.instret, 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst            = 1'b1;
    bus.opcode     = 5'b01100;
    bus.br_taken   = 1'b0;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    tick();
    do_reset();

    // ADD, zero-wait: FETCH, DECODE, EXEC, WB
    bus.opcode = 5'b01100;
    cyc("add F", 3'd0, sb(1, 1, 0, 2'd0, 0, 2'd0, 0, 0));
    cyc("add D", 3'd1, NONE);
    cyc("add E", 3'd2, NONE);
    cyc("add W", 3'd4, sb(0, 0, 1, 2'd0, 1, 2'd0, 0, 0));
    chk("add state", 32'(bus.state), 32'd0);
    chk("add instret", bus.instret, 32'd1);

    // LW with dmem_ready arriving on the 4th MEM cycle: 8 cycles total
    bus.opcode     = 5'b00000;
    bus.dmem_ready = 1'b0;
    cyc("lw F", 3'd0, sb(1, 1, 0, 2'd0, 0, 2'd0, 0, 0));
    cyc("lw D", 3'd1, NONE);
    cyc("lw E", 3'd2, NONE);
    cyc("lw M0", 3'd3, sb(0, 0, 0, 2'd0, 0, 2'd0, 1, 0));
    cyc("lw M1", 3'd3, sb(0, 0, 0, 2'd0, 0, 2'd0, 1, 0));
    cyc("lw M2", 3'd3, sb(0, 0, 0, 2'd0, 0, 2'd0, 1, 0));
    bus.dmem_ready = 1'b1;
    cyc("lw M3", 3'd3, sb(0, 0, 0, 2'd0, 0, 2'd0, 1, 0));
    cyc("lw W", 3'd4, sb(0, 0, 1, 2'd0, 1, 2'd1, 0, 0));
    chk("lw instret", bus.instret, 32'd2);

    // BEQ taken, then not taken: 3 cycles each, no rf_we
    bus.opcode   = 5'b11000;
    bus.br_taken = 1'b1;
    cyc("beq1 F", 3'd0, sb(1, 1, 0, 2'd0, 0, 2'd0, 0, 0));
    cyc("beq1 D", 3'd1, NONE);
    cyc("beq1 E", 3'd2, sb(0, 0, 1, 2'd1, 0, 2'd0, 0, 0));
    bus.br_taken = 1'b0;
    cyc("beq2 F", 3'd0, sb(1, 1, 0, 2'd0, 0, 2'd0, 0, 0));
    cyc("beq2 D", 3'd1, NONE);
    cyc("beq2 E", 3'd2, sb(0, 0, 1, 2'd0, 0, 2'd0, 0, 0));
    chk("beq instret", bus.instret, 32'd4);

    // JALR then JAL
    bus.opcode = 5'b11001;
    cyc("jalr F", 3'd0, sb(1, 1, 0, 2'd0, 0, 2'd0, 0, 0));
    cyc("jalr D", 3'd1, NONE);
    cyc("jalr E", 3'd2, NONE);
    cyc("jalr W", 3'd4, sb(0, 0, 1, 2'd2, 1, 2'd2, 0, 0));
    bus.opcode = 5'b11011;
    cyc("jal F", 3'd0, sb(1, 1, 0, 2'd0, 0, 2'd0, 0, 0));
    cyc("jal D", 3'd1, NONE);
    cyc("jal E", 3'd2, NONE);
    cyc("jal W", 3'd4, sb(0, 0, 1, 2'd1, 1, 2'd2, 0, 0));
    chk("jal instret", bus.instret, 32'd6);

    // SW, zero-wait: retires from MEM in 4 cycles
    bus.opcode = 5'b01000;
    cyc("sw F", 3'd0, sb(1, 1, 0, 2'd0, 0, 2'd0, 0, 0));
    cyc("sw D", 3'd1, NONE);
    cyc("sw E", 3'd2, NONE);
    cyc("sw M", 3'd3, sb(0, 0, 1, 2'd0, 0, 2'd0, 1, 1));
    chk("sw state", 32'(bus.state), 32'd0);
    chk("sw instret", bus.instret, 32'd7);

    // Illegal opcode 11100: DECODE -> HALT, absorbing for 20 cycles
    bus.opcode = 5'b11100;
    cyc("ill F", 3'd0, sb(1, 1, 0, 2'd0, 0, 2'd0, 0, 0));
    cyc("ill D", 3'd1, NONE);
    for (int i = 0; i < 20; i++) begin
      cyc("ill H", 3'd7, NONE);
    end
    chk("ill flags", {29'd0, bus.halted, bus.illegal, bus.bus_err}, 32'b110);
    chk("ill instret", bus.instret, 32'd7);
    do_reset();

    // imem_ready held low: 16 FETCH cycles then HALT with bus_err
    bus.opcode     = 5'b01100;
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc("to1 F", 3'd0, sb(1, 0, 0, 2'd0, 0, 2'd0, 0, 0));
    end
    #2;
    chk("to1 state", 32'(bus.state), 32'd7);
    chk("to1 flags", {29'd0, bus.halted, bus.illegal, bus.bus_err}, 32'b101);
    chk("to1 strobes", 32'(strobes), 32'(NONE));
    tick();
    do_reset();

    // Ready first seen at count==15: fetch completes, no bus error
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc("to2 F", 3'd0, sb(1, 0, 0, 2'd0, 0, 2'd0, 0, 0));
    end
    bus.imem_ready = 1'b1;
    cyc("to2 Fr", 3'd0, sb(1, 1, 0, 2'd0, 0, 2'd0, 0, 0));
    chk("to2 state", 32'(bus.state), 32'd1);
    chk("to2 bus_err", 32'(bus.bus_err), 32'd0);
    do_reset();

    // Reset during a MEM wait abandons the load
    bus.opcode     = 5'b00000;
    bus.dmem_ready = 1'b0;
    cyc("rm F", 3'd0, sb(1, 1, 0, 2'd0, 0, 2'd0, 0, 0));
    cyc("rm D", 3'd1, NONE);
    cyc("rm E", 3'd2, NONE);
    cyc("rm M0", 3'd3, sb(0, 0, 0, 2'd0, 0, 2'd0, 1, 0));
    cyc("rm M1", 3'd3, sb(0, 0, 0, 2'd0, 0, 2'd0, 1, 0));
    rst = 1'b1;
    #2;
    chk("rm rst dmem_req", 32'(bus.dmem_req), 32'd0);
    tick();
    rst = 1'b0;
    chk("rm state", 32'(bus.state), 32'd0);
    chk("rm dmem_req", 32'(bus.dmem_req), 32'd0);
    bus.dmem_ready = 1'b1;
    cyc("rm F2", 3'd0, sb(1, 1, 0, 2'd0, 0, 2'd0, 0, 0));
    chk("rm instret", bus.instret, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
